// File: rtl/controller_if.sv
// controller_if: command/status bundle between the game controller and the
// game datapath.
//
// Status (datapath -> controller): end_fpga, end_user, end_time, win, match
// Command (controller -> datapath): r1, r2, e1, e2, e3, e4, sel
//
// Signalling: every line is a level, valid on each rising clock edge. There
// is no valid/ready handshake. The controller samples a status flag only in
// the states that use it. A command line is asserted for exactly the cycles
// the controller sits in a state that decodes it.
//
// Modports:
//   master - the controller (reads status, drives commands)
//   slave  - the datapath   (drives status, reads commands)
interface controller_if;
  logic end_fpga;
  logic end_user;
  logic end_time;
  logic win;
  logic match;

  logic r1;
  logic r2;
  logic e1;
  logic e2;
  logic e3;
  logic e4;
  logic sel;

  modport master (
    input  end_fpga, end_user, end_time, win, match,
    output r1, r2, e1, e2, e3, e4, sel
  );

  modport slave (
    output end_fpga, end_user, end_time, win, match,
    input  r1, r2, e1, e2, e3, e4, sel
  );
endinterface

// File: rtl/controller.sv
// controller: Moore control unit for the memory-sequence game.
//
// The raw enter button passes through a 2-flop synchronizer and then a
// counter debouncer. A rising edge of the debounced level gives a one-cycle
// press. The state machine walks the game flow:
//   setup -> FPGA plays sequence -> user enters digits -> check
//   -> next round / result.
// It drives the datapath command lines from the state register only.
//
// Ports:
//   clock_50  in   system clock, all logic on its rising edge
//   reset     in   synchronous, active-high reset
//   enter     in   player confirm button, active-high, asynchronous, bouncy
//   bus       if   controller_if.master (status in, commands out)
//   state_dbg out  current state code
module controller #(
  parameter int DEB_CYCLES = 2_500_000,
  parameter int p_state    = 4
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               enter,
  controller_if.master       bus,
  output logic [p_state-1:0] state_dbg
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [p_state-1:0] S_INIT       = p_state'(0);
  localparam logic [p_state-1:0] S_SETUP      = p_state'(1);
  localparam logic [p_state-1:0] S_PLAY_FPGA  = p_state'(2);
  localparam logic [p_state-1:0] S_PLAY_USER  = p_state'(3);
  localparam logic [p_state-1:0] S_STORE      = p_state'(4);
  localparam logic [p_state-1:0] S_CHECK      = p_state'(5);
  localparam logic [p_state-1:0] S_NEXT_ROUND = p_state'(6);
  localparam logic [p_state-1:0] S_RESULT     = p_state'(7);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic             sync_a;
  logic             sync_b;
  logic             deb;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_flip;
  logic             press;

  // Flip on the cycle the counter has seen DEB_CYCLES consecutive
  // disagreements. The press pulse coincides with that flip, so it is
  // seen by the FSM on the same edge that deb rises.
  assign deb_flip = (sync_b != deb) && (deb_cnt == CNT_W'(DEB_CYCLES - 1));
  assign press    = deb_flip && sync_b;

  // Synchronizer and debouncer reset to 1. A button held through reset
  // must be released and pressed again before it counts.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync_a  <= 1'b1;
      sync_b  <= 1'b1;
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sync_a <= enter;
      sync_b <= sync_a;
      if (sync_b == deb) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        deb     <= sync_b;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  logic [p_state-1:0] state;
  logic [p_state-1:0] state_next;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // A press in a state that does not use it is simply dropped.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = S_INIT;
    case (state)
      S_INIT:      state_next = S_SETUP;
      S_SETUP:     state_next = press ? S_PLAY_FPGA : S_SETUP;
      S_PLAY_FPGA: state_next = bus.end_fpga ? S_PLAY_USER : S_PLAY_FPGA;
      S_PLAY_USER: begin
        // Timeout wins over a simultaneous press.
        if (bus.end_time)   state_next = S_RESULT;
        else if (press)     state_next = S_STORE;
        else                state_next = S_PLAY_USER;
      end
      S_STORE:     state_next = S_CHECK;
      S_CHECK: begin
        // A wrong digit loses even when it was the last digit.
        if (!bus.match)        state_next = S_RESULT;
        else if (bus.end_user) state_next = S_NEXT_ROUND;
        else                   state_next = S_PLAY_USER;
      end
      S_NEXT_ROUND: state_next = bus.win ? S_RESULT : S_PLAY_FPGA;
      S_RESULT:     state_next = press ? S_INIT : S_RESULT;
      default:      state_next = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output decode (state register only)
  // Illegal codes decode like INIT while they last one cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    bus.r1  = 1'b0;
    bus.r2  = 1'b0;
    bus.e1  = 1'b0;
    bus.e2  = 1'b0;
    bus.e3  = 1'b0;
    bus.e4  = 1'b0;
    bus.sel = 1'b0;
    case (state)
      S_SETUP:     bus.e1 = 1'b1;
      S_PLAY_FPGA: begin
        bus.e3 = 1'b1;
        bus.r2 = 1'b1;
      end
      S_PLAY_USER: bus.e2 = 1'b1;
      S_STORE:     bus.e4 = 1'b1;
      S_CHECK:     ;
      S_NEXT_ROUND: begin
        // r2 together with e4 tells the datapath to advance the round.
        bus.r2 = 1'b1;
        bus.e4 = 1'b1;
      end
      S_RESULT:    bus.sel = 1'b1;
      default: begin
        bus.r1 = 1'b1;
        bus.r2 = 1'b1;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_controller.sv
module tb_controller;

  localparam int DEB = 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       enter    = 1'b1;
  logic [3:0] state_dbg;

  always #5 clock_50 = ~clock_50;

  controller_if bus ();

  controller #(.DEB_CYCLES(DEB), .p_state(4)) dut (
    .clock_50  (clock_50),
    .reset     (reset),
    .enter     (enter),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Scoreboard counters and observation trackers
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int store_cnt = 0;     // e4 pulses that are STORE (not round advance)
  int setup_exits = 0;   // SETUP -> PLAY_FPGA transitions observed
  bit store_seen = 0;
  logic [3:0] prev_obs = 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: game flow written from the rules, plus a button
  // model where the debounced level follows the 2-cycle-delayed raw enter
  // once it has disagreed for DEB edges in a row.
  // ---------------------------------------------------------------------
  typedef enum int {M_INIT, M_SETUP, M_PLAY_FPGA, M_PLAY_USER,
                    M_STORE, M_CHECK, M_NEXT_ROUND, M_RESULT} mstate_t;

  mstate_t m_state = M_INIT;
  bit      raw_q[$];        // raw enter delay line (2 deep)
  bit      m_level = 1'b1;  // debounced level
  int      m_disagree = 0;  // consecutive edges the delayed input disagreed

  // Expected {r1,r2,e1,e2,e3,e4,sel} per game phase.
  function automatic logic [6:0] exp_outs(input mstate_t s);
    case (s)
      M_INIT:       return 7'b1100000;
      M_SETUP:      return 7'b0010000;
      M_PLAY_FPGA:  return 7'b0100100;
      M_PLAY_USER:  return 7'b0001000;
      M_STORE:      return 7'b0000010;
      M_CHECK:      return 7'b0000000;
      M_NEXT_ROUND: return 7'b0100010;
      default:      return 7'b0000001;
    endcase
  endfunction

  task automatic model_edge();
    bit seen;
    bit pressed;
    if (reset) begin
      m_state    = M_INIT;
      raw_q      = '{1'b1, 1'b1};
      m_level    = 1'b1;
      m_disagree = 0;
      return;
    end
    seen    = raw_q[0];
    pressed = 1'b0;
    if (seen == m_level) begin
      m_disagree = 0;
    end else begin
      m_disagree++;
      if (m_disagree == DEB) begin
        m_level    = seen;
        m_disagree = 0;
        pressed    = seen;
      end
    end
    void'(raw_q.pop_front());
    raw_q.push_back(enter);
    case (m_state)
      M_INIT:       m_state = M_SETUP;
      M_SETUP:      if (pressed) m_state = M_PLAY_FPGA;
      M_PLAY_FPGA:  if (bus.end_fpga) m_state = M_PLAY_USER;
      M_PLAY_USER:  if (bus.end_time) m_state = M_RESULT;
                    else if (pressed) m_state = M_STORE;
      M_STORE:      m_state = M_CHECK;
      M_CHECK:      if (!bus.match) m_state = M_RESULT;
                    else if (bus.end_user) m_state = M_NEXT_ROUND;
                    else m_state = M_PLAY_USER;
      M_NEXT_ROUND: m_state = bus.win ? M_RESULT : M_PLAY_FPGA;
      default:      if (pressed) m_state = M_INIT;
    endcase
  endtask

  // One clock: model advances on the same inputs the DUT samples, then
  // the DUT is compared 1 time unit after the edge.
  task automatic tick();
    @(posedge clock_50);
    model_edge();
    #1;
    check("state", {28'd0, state_dbg}, {28'd0, 4'(m_state)});
    check("outs", {25'd0, bus.r1, bus.r2, bus.e1, bus.e2, bus.e3, bus.e4, bus.sel},
          {25'd0, exp_outs(m_state)});
    if (bus.e4 && !bus.r2) store_cnt++;
    if (state_dbg == 4'd4) store_seen = 1'b1;
    if (prev_obs == 4'd1 && state_dbg == 4'd2) setup_exits++;
    prev_obs = state_dbg;
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Clean press: long enough to debounce, then release until settled.
  task automatic do_press();
    enter = 1'b1;
    ticks(6);
    enter = 1'b0;
    ticks(10);
  endtask

  task automatic pulse_end_fpga();
    bus.end_fpga = 1'b1;
    tick();
    bus.end_fpga = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
    int n = 0;
    while (state_dbg != s && n < budget) begin
      tick();
      n++;
    end
    check(tag, {28'd0, state_dbg}, {28'd0, s});
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int base;
    bus.end_fpga = 1'b0;
    bus.end_user = 1'b0;
    bus.end_time = 1'b0;
    bus.win      = 1'b0;
    bus.match    = 1'b1;

    // Reset with enter held; INIT values while reset is high.
    ticks(3);
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    check("rst_r1r2", {30'd0, bus.r1, bus.r2}, 32'd3);
    reset = 1'b0;
    tick();
    check("to_setup", {28'd0, state_dbg}, 32'd1);
    ticks(10);
    check("held_no_press", {28'd0, state_dbg}, 32'd1);
    enter = 1'b0;
    ticks(10);
    enter = 1'b1;
    ticks(3);
    enter = 1'b0;
    ticks(10);
    check("short_no_press", {28'd0, state_dbg}, 32'd1);

    // Debounce latency: 2 synchronizer + DEB cycles after the rise.
    enter = 1'b1;
    ticks(5);
    check("deb_lat_pre", {28'd0, state_dbg}, 32'd1);
    tick();
    check("deb_lat", {28'd0, state_dbg}, 32'd2);
    enter = 1'b0;
    ticks(10);

    // Full round: one digit, then last digit.
    pulse_end_fpga();
    check("play_user_e2", {28'd0, state_dbg, 3'd0, bus.e2}, 32'h31);
    base = store_cnt;
    do_press();
    check("one_store", store_cnt - base, 32'd1);
    check("back_user", {28'd0, state_dbg}, 32'd3);
    bus.end_user = 1'b1;
    do_press();
    bus.end_user = 1'b0;
    check("next_round", {28'd0, state_dbg}, 32'd2);

    // Lose on mismatch in CHECK even with end_user.
    pulse_end_fpga();
    bus.match = 1'b0;
    bus.end_user = 1'b1;
    do_press();
    bus.match = 1'b1;
    bus.end_user = 1'b0;
    check("lose_match", {28'd0, state_dbg, 3'd0, bus.sel}, 32'h71);

    // Restart, then bounce in SETUP gives exactly one press.
    do_press();
    check("restart", {28'd0, state_dbg}, 32'd1);
    base = setup_exits;
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      ticks(2);
    end
    enter = 1'b1;
    ticks(10);
    enter = 1'b0;
    ticks(10);
    check("bounce_one", setup_exits - base, 32'd1);
    check("bounce_state", {28'd0, state_dbg}, 32'd2);

    // Timeout and press on the same PLAY_USER edge.
    pulse_end_fpga();
    store_seen = 1'b0;
    enter = 1'b1;
    ticks(5);
    bus.end_time = 1'b1;
    tick();
    bus.end_time = 1'b0;
    enter = 1'b0;
    ticks(10);
    check("timeout_result", {28'd0, state_dbg}, 32'd7);
    check("timeout_nostore", {31'd0, store_seen}, 32'd0);

    // Win path.
    do_press();
    do_press();
    pulse_end_fpga();
    bus.end_user = 1'b1;
    bus.win = 1'b1;
    do_press();
    bus.end_user = 1'b0;
    bus.win = 1'b0;
    check("win_result", {28'd0, state_dbg, 3'd0, bus.sel}, 32'h71);

    // Mid-game reset from PLAY_USER.
    do_press();
    do_press();
    pulse_end_fpga();
    wait_state("reach_user", 4'd3, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst", {28'd0, state_dbg, 2'd0, bus.r1, bus.e2}, 32'h02);
    tick();
    check("mid_rst_setup", {28'd0, state_dbg}, 32'd1);

    // Randomized play against the model.
    for (int cyc = 0; cyc < 3000; ) begin
      int len;
      len   = $urandom_range(1, 12);
      enter = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        bus.end_fpga = ($urandom_range(0, 7) == 0);
        bus.end_time = ($urandom_range(0, 15) == 0);
        bus.match    = ($urandom_range(0, 3) != 0);
        bus.end_user = ($urandom_range(0, 2) == 0);
        bus.win      = ($urandom_range(0, 3) == 0);
        reset        = ($urandom_range(0, 299) == 0);
        tick();
      end
      cyc += len;
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Control unit for the memory-sequence game. It is the command/status counterpart of the game datapath.
- Consumes the datapath status flags (end_fpga, end_user, end_time, win, match) and a player "enter" button. Drives the datapath command lines r1, r2, e1..e4 and sel.
- Instantiated beside the datapath at top level, with the command outputs wired one-to-one to the datapath command inputs.

Parameters:
- DEB_CYCLES, 2_500_000, consecutive cycles raw enter must differ from its debounced value before the debounced value flips (50 ms at 50 MHz); legal range >= 1.
- p_state, 4, width of state register and state_dbg output.

Ports:
- clock_50  in  1  system clock, 50 MHz, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enter  in  1  player confirm button, active-high (KEY already inverted at top); asynchronous to the game, bouncy.
- end_fpga  in  1  datapath: FPGA sequence display finished.
- end_user  in  1  datapath: user has entered all digits of the current round.
- end_time  in  1  datapath: user time budget expired.
- win  in  1  datapath: final round completed.
- match  in  1  datapath: user sequence so far equals FPGA sequence.
- r1  out  1  global clear (setup, round, points, all counters).
- r2  out  1  per-round clear (time counter, user counter/register).
- e1  out  1  setup register load enable.
- e2  out  1  time counter enable.
- e3  out  1  FPGA sequence counter enable.
- e4  out  1  user-step enable; together with r2=1 it encodes round advance.
- sel  out  1  display select: 0 = setup/time/round view, 1 = result/points view.
- state_dbg  out  p_state  current state code, for LEDs and the bench.

Behaviour:
- Input conditioning:
  - enter passes through a 2-flop synchronizer, then the debouncer.
  - Debouncer: counter clears whenever sync == deb. It increments while sync != deb. When it reaches DEB_CYCLES-1 with sync != deb, deb <= sync and the counter clears.
  - Reset values: sync flops = 1, deb = 1, counter = 0. A held button therefore never produces a press after reset.
  - press = one-cycle pulse on deb 0->1. A press arriving in a state that does not consume it is discarded, never queued.
- FSM: Moore. Outputs decode from the state register only, so they change the cycle after the triggering edge. Unlisted outputs are 0.
- Reset: state <= INIT on any clock_50 edge with reset=1, including mid-game. While reset is high, outputs show INIT values: r1=1, r2=1, e1..e4=0, sel=0, state_dbg=0.
- States (code: outputs; transitions):
  - INIT (0): r1=1, r2=1. -> SETUP unconditionally.
  - SETUP (1): e1=1. press -> PLAY_FPGA; else stay.
  - PLAY_FPGA (2): e3=1, r2=1. end_fpga=1 -> PLAY_USER; else stay.
  - PLAY_USER (3): e2=1. end_time=1 -> RESULT (priority); else press -> STORE; else stay.
  - STORE (4): e4=1 for exactly one cycle. -> CHECK.
  - CHECK (5): no enables; the datapath has settled after STORE. match=0 -> RESULT (priority); else end_user=1 -> NEXT_ROUND; else -> PLAY_USER.
  - NEXT_ROUND (6): r2=1, e4=1 (round advance). win=1 -> RESULT; else -> PLAY_FPGA.
  - RESULT (7): sel=1. press -> INIT; else stay.
- Illegal state codes 8..15 -> INIT on the next edge, with INIT outputs.
- Time is not counted while in STORE or CHECK (e2=0). Only one e4 pulse occurs per press.
- Status inputs are sampled only in the states listed. Glitches on them in other states are ignored.

Test Plan:
- Reset/debounce, DEB_CYCLES=4:
  - enter held 1 through reset, released, then pressed for 3 cycles -> no press, state_dbg stays 1.
  - Pressed 6 cycles -> press, state_dbg 1->2 exactly 4+2 cycles after the enter rise (2 synchronizer + 4 debounce).
- Bounce:
  - enter toggles every 2 cycles for 20 cycles, then stable high -> exactly one press, one e1-phase exit.
- Full round:
  - end_fpga pulse in PLAY_FPGA -> PLAY_USER with e2=1.
  - press with match=1, end_user=0 -> STORE (e4=1 for 1 cycle), CHECK, back to PLAY_USER.
  - Next press with end_user=1 -> NEXT_ROUND (r2=e4=1), then PLAY_FPGA.
- Lose paths:
  - In CHECK with match=0 and end_user=1 -> RESULT, sel=1.
  - Separately, end_time=1 and press in the same PLAY_USER cycle -> RESULT, with no STORE visited.
- Win path and restart:
  - NEXT_ROUND with win=1 -> RESULT, sel=1.
  - press -> INIT (r1=r2=1 for one cycle) -> SETUP.
- Mid-game reset:
  - reset=1 for one cycle while in PLAY_USER -> next cycle state_dbg=0, r1=1, e2=0. One cycle later state_dbg=1.
